// File: rtl/div_pkg.sv
// Shared status codes, requester state encoding and defaults for the
// divider requester slice.
package div_pkg;

    localparam int DEFAULT_DATA_W  = 10;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_DVZ     = 2'b01,
        ST_OVF     = 2'b10,
        ST_TIMEOUT = 2'b11
    } div_status_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        REPORT    = 3'd4
    } req_state_e;

    // Busy fell without a result: divide-by-zero wins, anything else is overflow.
    function automatic div_status_e classify_abort(input logic dvz_seen, input logic ovf_seen);
        if (dvz_seen) return ST_DVZ;
        if (ovf_seen) return ST_OVF;
        return ST_OVF;
    endfunction

endpackage

// File: rtl/div_watchdog.sv
// Loadable up-counter with clear and a terminal-count flag at TIMEOUT-1.
// The count saturates at terminal so it can never wrap back to zero.
module div_watchdog
    import div_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int CNT_W  = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             inc,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] TERMINAL_COUNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc && !terminal) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == TERMINAL_COUNT);

endmodule

// File: rtl/div_requester.sv
// Initiator-side sequencer for the sequential divider: accepts one operand
// pair, issues a single divide, classifies the outcome and returns it.
module div_requester
    import div_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_q,
    output logic [1:0]        res_status,
    output logic              div_start,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic              div_busy,
    input  logic              div_valid,
    input  logic [DATA_W-1:0] div_q,
    input  logic              div_dvz,
    input  logic              div_ovf
);

    req_state_e        state, state_next;
    logic [DATA_W-1:0] a_reg, b_reg, q_reg;
    div_status_e       status_reg;
    logic              dvz_sticky, ovf_sticky;

    logic              latch_req;
    logic              wd_clear;
    logic              wd_inc;
    logic              wd_terminal;
    logic              capture;
    logic [DATA_W-1:0] q_next;
    div_status_e       status_next;
    logic              in_flight;

    div_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear     (wd_clear),
        .load      (1'b0),
        .load_value('0),
        .inc       (wd_inc),
        .terminal  (wd_terminal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign in_flight = (state == WAIT_BUSY) || (state == RUN);

    // A flag arriving in the same cycle busy falls still counts.
    always_comb begin
        state_next  = state;
        latch_req   = 1'b0;
        wd_clear    = 1'b0;
        wd_inc      = 1'b0;
        capture     = 1'b0;
        q_next      = '0;
        status_next = ST_OK;

        case (state)
            IDLE: begin
                if (req_valid && !div_busy) begin
                    latch_req  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                wd_clear   = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                wd_inc = 1'b1;
                if (wd_terminal) begin
                    capture     = 1'b1;
                    status_next = ST_TIMEOUT;
                    state_next  = REPORT;
                end else if (div_busy) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                wd_inc = 1'b1;
                if (div_valid) begin
                    capture     = 1'b1;
                    q_next      = div_q;
                    status_next = ST_OK;
                    state_next  = REPORT;
                end else if (!div_busy) begin
                    capture     = 1'b1;
                    status_next = classify_abort(dvz_sticky | div_dvz, ovf_sticky | div_ovf);
                    state_next  = REPORT;
                end else if (wd_terminal) begin
                    capture     = 1'b1;
                    status_next = ST_TIMEOUT;
                    state_next  = REPORT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            q_reg      <= '0;
            status_reg <= ST_OK;
            dvz_sticky <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (latch_req) begin
                a_reg <= req_a;
                b_reg <= req_b;
            end
            if (capture) begin
                q_reg      <= q_next;
                status_reg <= status_next;
            end
            if (wd_clear) begin
                dvz_sticky <= 1'b0;
                ovf_sticky <= 1'b0;
            end else if (in_flight) begin
                if (div_dvz) dvz_sticky <= 1'b1;
                if (div_ovf) ovf_sticky <= 1'b1;
            end
        end
    end

    assign req_ready  = (state == IDLE) && !div_busy;
    assign res_valid  = (state == REPORT);
    assign res_q      = q_reg;
    assign res_status = status_reg;
    assign div_start  = (state == ISSUE);
    assign div_a      = a_reg;
    assign div_b      = b_reg;

endmodule

// File: tb/tb_div_requester.sv
// Randomised scoreboard bench for div_requester, driving it with a
// behavioural divider and checking results against a reference model.
module tb_div_requester;

    localparam int W          = 10;
    localparam int TB_TIMEOUT = 8;

    localparam int M_NORMAL  = 0;
    localparam int M_OVF     = 1;
    localparam int M_TIMEOUT = 2;
    localparam int M_HANG    = 3;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [1:0]   status;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_q;
    logic [1:0]   res_status;
    logic         div_start;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic         div_busy;
    logic         div_valid;
    logic [W-1:0] div_q;
    logic         div_dvz;
    logic         div_ovf;

    int           compared   = 0;
    int           mismatched = 0;
    exp_t         sb[$];
    int           cur_mode;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;
    logic         hang_release;
    int           cyc = 0;
    int           start_count = 0;
    int           start_cyc = 0;
    int           last_latency = -1;
    int           txn_start_base = 0;

    div_requester #(
        .DATA_W (W),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_q     (res_q),
        .res_status(res_status),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_busy  (div_busy),
        .div_valid (div_valid),
        .div_q     (div_q),
        .div_dvz   (div_dvz),
        .div_ovf   (div_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failBound(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    // Reference: outcome follows only from operands and how the divider behaves.
    function automatic exp_t refResult(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = '0;      e.status = 2'b01;
        end else if (mode == M_OVF) begin
            e.q = '0;      e.status = 2'b10;
        end else if (mode == M_TIMEOUT) begin
            e.q = '0;      e.status = 2'b11;
        end else begin
            e.q = a / b;   e.status = 2'b00;
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        int n = 0;
        cur_mode       = mode;
        cur_a          = a;
        cur_b          = b;
        txn_start_base = start_count;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                failBound("req_accept");
                break;
            end
        end
        if (mode != M_HANG) sb.push_back(refResult(a, b, mode));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("start_latency", {31'd0, div_start}, 32'd1);
    endtask

    task automatic waitDone(input bit stall);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            res_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        res_ready = 1'b1;
        if (sb.size() != 0) begin
            failBound("result_wait");
            sb.delete();
        end
        checkOutput("start_pulses", start_count - txn_start_base, 32'd1);
    endtask

    task automatic runTxn(input logic [W-1:0] a, input logic [W-1:0] b, input int mode, input bit stall);
        applyStimulus(a, b, mode);
        waitDone(stall);
        if (mode == M_TIMEOUT && b != 0)
            checkOutput("timeout_latency", last_latency, TB_TIMEOUT + 1);
    endtask

    // Behavioural divider: reacts to div_start according to cur_mode.
    task automatic runDivider();
        int lat;
        if (cur_mode == M_HANG) begin
            @(posedge clk); #1;
            div_busy = 1'b1;
            for (int i = 0; i < 500; i++) begin
                @(posedge clk); #1;
                if (hang_release) break;
            end
            div_busy = 1'b0;
        end else if (div_b == 0) begin
            @(posedge clk); #1;
            div_busy = 1'b1;
            div_dvz  = 1'b1;
            @(posedge clk); #1;
            div_busy = 1'b0;
            div_dvz  = 1'b0;
        end else if (cur_mode == M_OVF) begin
            @(posedge clk); #1;
            div_busy = 1'b1;
            @(negedge clk);
            checkOutput("div_a_held", div_a, cur_a);
            checkOutput("div_b_held", div_b, cur_b);
            @(posedge clk); #1;
            div_ovf = 1'b1;
            @(posedge clk); #1;
            div_ovf  = 1'b0;
            div_busy = 1'b0;
        end else if (cur_mode == M_NORMAL) begin
            lat = $urandom_range(1, 4);
            @(posedge clk); #1;
            div_busy = 1'b1;
            @(negedge clk);
            checkOutput("div_a_held", div_a, cur_a);
            checkOutput("div_b_held", div_b, cur_b);
            repeat (lat) @(posedge clk);
            #1;
            div_valid = 1'b1;
            div_q     = div_a / div_b;
            @(posedge clk); #1;
            div_valid = 1'b0;
            div_busy  = 1'b0;
            div_q     = '0;
        end
    endtask

    initial begin : divider_model
        div_busy  = 1'b0;
        div_valid = 1'b0;
        div_q     = '0;
        div_dvz   = 1'b0;
        div_ovf   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && div_start) runDivider();
        end
    end

    initial begin : start_watcher
        logic prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (div_start) begin
                start_count++;
                start_cyc = cyc;
            end
            if (res_valid && !prev_rv) last_latency = cyc - start_cyc;
            prev_rv = res_valid;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    failBound("unexpected_result");
                end else begin
                    e = sb.pop_front();
                    checkOutput("res_q", res_q, e.q);
                    checkOutput("res_status", res_status, e.status);
                    checkOutput("div_a_end", div_a, e.a);
                    checkOutput("div_b_end", div_b, e.b);
                end
            end
        end
    end

    initial begin : guard
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] aborted");
    end

    initial begin : main
        logic [W-1:0] ra, rb;
        int           rmode, r;
        int           n;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_a        = '0;
        req_b        = '0;
        res_ready    = 1'b1;
        hang_release = 1'b0;
        cur_mode     = M_NORMAL;
        cur_a        = '0;
        cur_b        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_div_start", {31'd0, div_start}, 32'd0);
        checkOutput("rst_res_q", res_q, 32'd0);
        checkOutput("rst_res_status", res_status, 32'd0);
        checkOutput("rst_div_a", div_a, 32'd0);
        checkOutput("rst_div_b", div_b, 32'd0);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] directed transactions");
        runTxn(10'd100, 10'd7, M_NORMAL, 1'b0);
        runTxn(10'd123, 10'd0, M_NORMAL, 1'b0);
        runTxn(10'd200, 10'd3, M_OVF, 1'b0);
        runTxn(10'd1023, 10'd1, M_NORMAL, 1'b0);
        runTxn(10'd50, 10'd5, M_TIMEOUT, 1'b0);

        $display("[TB] result back-pressure");
        res_ready = 1'b0;
        applyStimulus(10'd100, 10'd7, M_NORMAL);
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) failBound("report_wait");
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_a     = 10'd3;
        req_b     = 10'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_res_valid", {31'd0, res_valid}, 32'd1);
            checkOutput("stall_res_q", res_q, 32'd14);
            checkOutput("stall_res_status", res_status, 32'd0);
            checkOutput("stall_req_ready", {31'd0, req_ready}, 32'd0);
            checkOutput("stall_div_start", {31'd0, div_start}, 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        waitDone(1'b0);

        $display("[TB] reset during RUN");
        applyStimulus(10'd300, 10'd9, M_HANG);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("midrst_res_q", res_q, 32'd0);
        checkOutput("midrst_res_status", res_status, 32'd0);
        checkOutput("midrst_div_start", {31'd0, div_start}, 32'd0);
        checkOutput("midrst_div_a", div_a, 32'd0);
        checkOutput("midrst_div_b", div_b, 32'd0);
        checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_a     = 10'd5;
        req_b     = 10'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("drain_req_ready", {31'd0, req_ready}, 32'd0);
            checkOutput("drain_div_start", {31'd0, div_start}, 32'd0);
        end
        @(posedge clk); #1;
        req_valid    = 1'b0;
        hang_release = 1'b1;
        n = 0;
        while (div_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (div_busy) failBound("busy_release");
        hang_release = 1'b0;
        runTxn(10'd55, 10'd5, M_NORMAL, 1'b0);

        $display("[TB] randomised transactions");
        for (int t = 0; t < 40; t++) begin
            ra = W'($urandom_range(0, 1023));
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 1023));
            r  = $urandom_range(0, 9);
            rmode = (r == 0) ? M_OVF : (r == 1) ? M_TIMEOUT : M_NORMAL;
            runTxn(ra, rb, rmode, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div_requester.md
Name: div_requester

Overview:
Initiator-side sequencer for the team's sequential divider: drives its start/busy/valid/dvz/ovf handshake.
- Accepts operand pairs on a valid/ready request port and issues one divide per pair.
- Classifies termination as OK, divide-by-zero, overflow or watchdog timeout, and returns quotient plus status on a valid/ready result port.
- Sits between the host/test sequencer and the divider datapath and controller.

Parameters:
DATA_W, 10, width of dividend, divisor and quotient
TIMEOUT, 255, max cycles from issue to termination before TIMEOUT status (>=2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  operand pair offered
req_ready  out  1  block accepts operand pair
req_a  in  DATA_W  dividend
req_b  in  DATA_W  divisor
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_q  out  DATA_W  quotient (0 unless status OK)
res_status  out  2  00 OK, 01 DVZ, 10 OVF, 11 TIMEOUT
div_start  out  1  one-cycle start pulse to divider
div_a  out  DATA_W  dividend to divider
div_b  out  DATA_W  divisor to divider
div_busy  in  1  divider busy
div_valid  in  1  divider result strobe
div_q  in  DATA_W  divider quotient
div_dvz  in  1  divider divide-by-zero flag
div_ovf  in  1  divider overflow flag

Behaviour:
- Reset (sync, active-high):
  - state IDLE; all outputs 0.
  - Operand and result registers, sticky flags and counter cleared.
- Reset mid-operation: IDLE on next edge; divider is not reset by this block.
- States: IDLE, ISSUE, WAIT_BUSY, RUN, REPORT.
- IDLE:
  - req_ready = !div_busy, so no issue while a previous divide drains.
  - On req_valid && req_ready: latch req_a/req_b, go to ISSUE.
- div_a/div_b are driven from the latched registers at all times, so they are stable across the whole transaction.
- ISSUE:
  - div_start=1 for exactly this cycle.
  - Counter and sticky dvz/ovf flags cleared; go to WAIT_BUSY.
- WAIT_BUSY: div_busy=1 -> RUN.
- RUN, in priority order:
  1. div_valid=1: capture div_q, status OK, go to REPORT.
  2. div_busy=0 (busy fell without valid): status DVZ if sticky dvz set, else OVF; q=0; go to REPORT.
- Sticky flags set whenever div_dvz/div_ovf is seen high in WAIT_BUSY or RUN.
- Watchdog:
  - Counter increments each WAIT_BUSY/RUN cycle.
  - If counter==TIMEOUT-1 and no termination that cycle: status TIMEOUT, q=0, go to REPORT.
  - A termination in the same cycle wins over timeout.
- REPORT:
  - res_valid=1; res_q/res_status held stable until res_ready.
  - On res_ready: res_valid drops next edge, go to IDLE.
  - req_ready=0 throughout.
- Latency: div_start occurs 1 cycle after request acceptance. With a ready consumer, res_valid rises 1 cycle after termination is detected.
- One transaction in flight; no operand buffering beyond the latch.
- Width: the quotient is passed through unmodified; no arithmetic is done here.

Decomposition:
- Shared package div_pkg:
  - status codes ST_OK/ST_DVZ/ST_OVF/ST_TIMEOUT
  - requester state encoding
  - default DATA_W
- One natural sub-module: div_watchdog. It is a loadable up-counter with clear and a terminal-count flag, parameterised by TIMEOUT.

Test Plan:
- Behavioural divider model, a=100, b=7:
  - exactly one div_start pulse
  - div_a=100, div_b=7 held throughout
  - res_q=14, res_status=00
- b=0; model raises busy 1 cycle, pulses dvz, drops busy with no valid -> res_status=01, res_q=0.
- Model asserts ovf then drops busy with no valid -> res_status=10, res_q=0.
- TIMEOUT=8; model never raises busy -> res_valid first high 9 cycles after the div_start cycle, res_status=11.
- res_ready held low 5 cycles during REPORT -> res_valid, res_q and res_status stable; req_ready=0; a concurrent req_valid is not accepted.
- rst pulsed while in RUN -> next cycle all outputs 0 and state IDLE. With div_busy still high, req_ready stays 0 until div_busy falls, then the next request issues normally.
